quant_stream: RTL and testbench

- Parametrised streaming quantiser for the JPEG path. It sits between the 2-D DCT column output and the zig-zag/entropy stage.
- Each accepted beat carries one column of an 8x8 coefficient block: 8 signed lanes, lane r = row r.
- Each lane is multiplied by a reciprocal quantisation coefficient, selected by row, column and table (luma/chroma). The product is scaled by 2^-FRAC, rounded or truncated, then saturated.
- Compared with the previous quantiser it adds: signed data, a second table, a rounding mode, saturation, valid/ready flow control and block framing.

---
 rtl/quant_stream.sv | 194 +++++++++++++++++++
 tb/tb_quant_stream.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quant_stream.sv
// quant_stream: streaming JPEG coefficient quantiser.
//
// Each input beat is one column of an 8x8 DCT block. There are 8 signed lanes
// and lane r holds row r. Each lane is multiplied by a reciprocal quantisation
// coefficient taken from a luma or chroma ROM. The product is scaled by
// 2^-FRAC, truncated toward zero or rounded half away from zero, and then
// saturated to OUT_W bits.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   / in_ready   input handshake (in_ready depends only on the
//                           output side)
//   in_sof     beat is column 0 of a new block; resynchronises the counter
//   in_data    8 lanes of IN_W-bit two's complement, lane r at [r*IN_W +: IN_W]
//   table_sel  0 = luma, 1 = chroma; sampled on column-0 beats only
//   round_mode 0 = truncate toward zero, 1 = round half away from zero
//   out_valid  / out_ready  output handshake
//   out_data   8 lanes of OUT_W-bit signed results
//   out_col    column index of the output beat
//   out_last   high when out_col == 7
module quant_stream #(
    parameter int IN_W  = 20,
    parameter int Q_W   = 8,
    parameter int FRAC  = 7,
    parameter int OUT_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic [8*IN_W-1:0]    in_data,
    input  logic                 table_sel,
    input  logic                 round_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   out_data,
    output logic [2:0]           out_col,
    output logic                 out_last
);

    localparam int PW = IN_W + Q_W + 1;
    localparam logic [PW-1:0] HALF    = PW'(1) << (FRAC - 1);
    localparam logic [PW-1:0] POS_MAX = PW'((2 ** (OUT_W - 1)) - 1);
    localparam logic [PW-1:0] NEG_MAX = PW'(2 ** (OUT_W - 1));

    // Each ROM row is packed with column 0 in the most significant byte, so the
    // literals read in the same order as the quantisation tables.
    function automatic logic [63:0] luma_row(input logic [2:0] r);
        case (r)
            3'd0:    luma_row = {8'd8,  8'd12, 8'd13, 8'd8, 8'd5, 8'd3, 8'd3, 8'd2};
            3'd1:    luma_row = {8'd11, 8'd11, 8'd9,  8'd7, 8'd5, 8'd2, 8'd2, 8'd2};
            3'd2:    luma_row = {8'd9,  8'd10, 8'd8,  8'd5, 8'd3, 8'd2, 8'd2, 8'd2};
            3'd3:    luma_row = {8'd9,  8'd8,  8'd6,  8'd4, 8'd3, 8'd1, 8'd2, 8'd2};
            3'd4:    luma_row = {8'd7,  8'd6,  8'd3,  8'd2, 8'd2, 8'd1, 8'd1, 8'd2};
            3'd5:    luma_row = {8'd5,  8'd4,  8'd2,  8'd2, 8'd2, 8'd1, 8'd1, 8'd1};
            3'd6:    luma_row = {8'd3,  8'd2,  8'd2,  8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
            default: luma_row = {8'd2,  8'd1,  8'd1,  8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        endcase
    endfunction

    function automatic logic [63:0] chroma_row(input logic [2:0] r);
        case (r)
            3'd0:    chroma_row = {8'd8, 8'd7, 8'd5, 8'd3, 8'd1, 8'd1, 8'd1, 8'd1};
            3'd1:    chroma_row = {8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1};
            3'd2:    chroma_row = {8'd5, 8'd5, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
            3'd3:    chroma_row = {8'd3, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
            default: chroma_row = {8{8'd1}};
        endcase
    endfunction

    logic                  en;
    logic                  accept;
    logic [2:0]            col_used;
    logic                  tbl_used;

    logic [2:0]            cnt_q;
    logic                  tbl_q;

    logic                  s1_valid_q;
    logic                  s1_rnd_q;
    logic [2:0]            s1_col_q;
    logic signed [PW-1:0]  s1_p_q [8];
    logic signed [PW-1:0]  prod_d [8];

    logic                  s2_valid_q;
    logic [8*OUT_W-1:0]    out_data_q;
    logic [2:0]            out_col_q;
    logic                  out_last_q;
    logic [OUT_W-1:0]      lane_d [8];

    // The whole pipeline advances together. The input may only be taken when
    // the output register is free or is being drained in this cycle.
    assign en       = !s2_valid_q || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // A start-of-frame beat overrides the running column position. Column-0
    // beats use table_sel directly; every later beat uses the latched table.
    assign col_used = in_sof ? 3'd0 : cnt_q;
    assign tbl_used = (col_used == 3'd0) ? table_sel : tbl_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [63:0]          row_bits;
        logic [Q_W-1:0]       coef;
        logic signed [IN_W-1:0] x_lane;
        logic signed [PW-1:0] x_ext;
        logic signed [PW-1:0] c_ext;

        logic                 neg;
        logic [PW-1:0]        mag;
        logic [PW-1:0]        qm;
        logic [PW-1:0]        neg_qm;

        // S1: coefficient lookup and signed multiply. The coefficient is
        // zero-extended, so the product takes the sign of the input.
        always_comb begin
            row_bits   = tbl_used ? chroma_row(3'(gi)) : luma_row(3'(gi));
            coef       = Q_W'(row_bits[{~col_used, 3'b000} +: 8]);
            x_lane     = in_data[gi*IN_W +: IN_W];
            x_ext      = x_lane;
            c_ext      = {{(PW-Q_W){1'b0}}, coef};
            prod_d[gi] = x_ext * c_ext;
        end

        // S2: scale the magnitude so the result is symmetric about zero, then
        // restore the sign and clamp it to the output range.
        always_comb begin
            neg    = s1_p_q[gi][PW-1];
            mag    = neg ? PW'(-s1_p_q[gi]) : PW'(s1_p_q[gi]);
            if (s1_rnd_q) begin
                mag = mag + HALF;
            end
            qm     = mag >> FRAC;
            neg_qm = -qm;
            if (!neg) begin
                lane_d[gi] = (qm > POS_MAX) ? POS_MAX[OUT_W-1:0] : qm[OUT_W-1:0];
            end else begin
                lane_d[gi] = (qm > NEG_MAX) ? NEG_MAX[OUT_W-1:0] : neg_qm[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= 3'd0;
            tbl_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_rnd_q   <= 1'b0;
            s1_col_q   <= 3'd0;
            for (int r = 0; r < 8; r++) begin
                s1_p_q[r] <= '0;
            end
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_col_q  <= 3'd0;
            out_last_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= col_used + 3'd1;
                if (col_used == 3'd0) begin
                    tbl_q <= table_sel;
                end
            end
            if (en) begin
                s1_valid_q <= accept;
                if (accept) begin
                    for (int r = 0; r < 8; r++) begin
                        s1_p_q[r] <= prod_d[r];
                    end
                    s1_rnd_q <= round_mode;
                    s1_col_q <= col_used;
                end
                s2_valid_q <= s1_valid_q;
                // The output fields change only when a new result arrives, so
                // they stay stable while a beat is waiting for out_ready.
                if (s1_valid_q) begin
                    for (int r = 0; r < 8; r++) begin
                        out_data_q[r*OUT_W +: OUT_W] <= lane_d[r];
                    end
                    out_col_q  <= s1_col_q;
                    out_last_q <= (s1_col_q == 3'd7);
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_quant_stream.sv
// tb_quant_stream: bench for quant_stream. Directed steps and random streams
// are run from a single initial block. Every output beat is compared with an
// arithmetic reference model of the quantiser.
module tb_quant_stream;

    localparam int IN_W  = 20;
    localparam int Q_W   = 8;
    localparam int FRAC  = 7;
    localparam int OUT_W = 12;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic                in_sof;
    logic [8*IN_W-1:0]   in_data;
    logic                table_sel;
    logic                round_mode;
    logic                out_valid;
    logic                out_ready;
    logic [8*OUT_W-1:0]  out_data;
    logic [2:0]          out_col;
    logic                out_last;

    quant_stream #(.IN_W(IN_W), .Q_W(Q_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .table_sel  (table_sel),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Quantisation tables indexed [row][column].
    int luma_t [0:7][0:7] = '{
        '{8, 12, 13, 8, 5, 3, 3, 2},
        '{11, 11, 9, 7, 5, 2, 2, 2},
        '{9, 10, 8, 5, 3, 2, 2, 2},
        '{9, 8, 6, 4, 3, 1, 2, 2},
        '{7, 6, 3, 2, 2, 1, 1, 2},
        '{5, 4, 2, 2, 2, 1, 1, 1},
        '{3, 2, 2, 1, 1, 1, 1, 1},
        '{2, 1, 1, 1, 1, 1, 1, 1}
    };
    int chroma_t [0:7][0:7] = '{
        '{8, 7, 5, 3, 1, 1, 1, 1},
        '{7, 6, 5, 2, 1, 1, 1, 1},
        '{5, 5, 2, 1, 1, 1, 1, 1},
        '{3, 2, 1, 1, 1, 1, 1, 1},
        '{1, 1, 1, 1, 1, 1, 1, 1},
        '{1, 1, 1, 1, 1, 1, 1, 1},
        '{1, 1, 1, 1, 1, 1, 1, 1},
        '{1, 1, 1, 1, 1, 1, 1, 1}
    };

    typedef struct packed {
        logic [8*OUT_W-1:0] data;
        logic [2:0]         col;
        logic               last;
    } exp_t;

    exp_t               exp_q [$];
    int                 tests = 0;
    int                 fails = 0;
    int                 x_arr [8];
    int                 m_cnt = 0;
    bit                 m_tbl = 1'b0;
    bit                 acc_flag;
    bit                 hold_chk = 1'b0;
    logic [8*OUT_W-1:0] held_data;
    logic [2:0]         held_col;
    int                 n_consumed = 0;
    int                 n_last = 0;

    task automatic chk(input string tag, input longint obs, input longint expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chkv(input string tag, input logic [8*OUT_W-1:0] obs,
                        input logic [8*OUT_W-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic: scale the magnitude, round or truncate it,
    // reapply the sign, then clamp.
    function automatic longint ref_q(input longint x, input int c, input bit rnd);
        longint m;
        m = (x < 0 ? -x : x) * c;
        if (rnd) m = m + (longint'(1) << (FRAC - 1));
        m = m / (longint'(1) << FRAC);
        if (x < 0) m = -m;
        if (m > (longint'(1) << (OUT_W - 1)) - 1) m = (longint'(1) << (OUT_W - 1)) - 1;
        if (m < -(longint'(1) << (OUT_W - 1))) m = -(longint'(1) << (OUT_W - 1));
        return m;
    endfunction

    function automatic longint lane(input int r);
        logic signed [OUT_W-1:0] v;
        v = out_data[r*OUT_W +: OUT_W];
        return longint'(v);
    endfunction

    function automatic int rand_x();
        int t;
        t = $urandom;
        return t >>> (32 - IN_W);
    endfunction

    task automatic model_push();
        int   cu;
        bit   t;
        exp_t e;
        cu = in_sof ? 0 : m_cnt;
        t  = (cu == 0) ? table_sel : m_tbl;
        if (cu == 0) m_tbl = table_sel;
        m_cnt = (cu + 1) % 8;
        e.data = '0;
        for (int r = 0; r < 8; r++) begin
            e.data[r*OUT_W +: OUT_W] =
                OUT_W'(ref_q(x_arr[r], t ? chroma_t[r][cu] : luma_t[r][cu], round_mode));
        end
        e.col  = 3'(cu);
        e.last = (cu == 7);
        exp_q.push_back(e);
    endtask

    task automatic set_beat(input bit sof, input bit tsel, input bit rnd);
        in_sof     = sof;
        table_sel  = tsel;
        round_mode = rnd;
        in_valid   = 1'b1;
        for (int r = 0; r < 8; r++) begin
            in_data[r*IN_W +: IN_W] = x_arr[r][IN_W-1:0];
        end
    endtask

    // One clock: check the handshakes at the negedge, then advance past the
    // next posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (hold_chk) begin
            chkv("stall_data", out_data, held_data);
            chk("stall_col", out_col, held_col);
        end
        hold_chk  = out_valid && !out_ready;
        held_data = out_data;
        held_col  = out_col;
        if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chkv("out_data", out_data, e.data);
                chk("out_col", out_col, e.col);
                chk("out_last", out_last, e.last);
                $display("[TB] beat col=%0d last=%0d data=%h", out_col, out_last, out_data);
            end
            n_consumed++;
            if (out_last) n_last++;
        end
        acc_flag = in_valid && in_ready;
        if (acc_flag) model_push();
        @(posedge clk);
        #1;
    endtask

    // Sends a single beat into an otherwise empty pipeline and captures the
    // result as soon as it appears.
    task automatic one_beat(input bit sof, input bit tsel, input bit rnd,
                            input int x0, input int xr,
                            output longint l0, output longint l7, output int col);
        x_arr[0] = x0;
        for (int r = 1; r < 8; r++) x_arr[r] = xr;
        set_beat(sof, tsel, rnd);
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("latency_s1_empty_out", out_valid, 0);
        step();
        chk("latency_out_valid", out_valid, 1);
        l0  = lane(0);
        l7  = lane(7);
        col = int'(out_col);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint l0, l7;
        int     col;
        int     sent, base_c, base_l;
        bit     cur_tsel, cur_rnd;

        reset      = 1'b0;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_data    = '0;
        table_sel  = 1'b0;
        round_mode = 1'b0;
        out_ready  = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chkv("rst_out_data", out_data, '0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single beats with all lanes at +/-1000 on luma column 0.
        one_beat(1, 0, 0, 1000, 1000, l0, l7, col);
        chk("t1_col", col, 0);
        chk("t1_lane0_trunc", l0, 62);
        chk("t1_lane7_trunc", l7, 15);
        one_beat(1, 0, 1, 1000, 1000, l0, l7, col);
        chk("t1_lane0_round", l0, 63);
        one_beat(1, 0, 0, -1000, -1000, l0, l7, col);
        chk("neg_lane0_trunc", l0, -62);
        chk("neg_lane7_trunc", l7, -15);
        one_beat(1, 0, 1, -1000, -1000, l0, l7, col);
        chk("neg_lane0_round", l0, -63);
        chk("neg_lane7_round", l7, -16);
        one_beat(1, 0, 1, 0, 0, l0, l7, col);
        chk("zero_round", l0, 0);

        // Saturation at column 2 (coef 13), then column 3 for the negative limit.
        one_beat(1, 0, 0, 5, 5, l0, l7, col);
        one_beat(0, 0, 0, 5, 5, l0, l7, col);
        one_beat(0, 0, 0, 524287, 3, l0, l7, col);
        chk("sat_col", col, 2);
        chk("sat_pos", l0, 2047);
        one_beat(0, 0, 1, -524288, 3, l0, l7, col);
        chk("sat_neg", l0, -2048);

        // Two seamless blocks. Table changes on non-column-0 beats are ignored.
        base_l = n_last;
        for (int i = 0; i < 16; i++) begin
            for (int r = 0; r < 8; r++) x_arr[r] = rand_x();
            set_beat(i == 0, !(i == 3 || i == 8), 1'($urandom));
            step();
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("blocks_last_count", n_last - base_l, 2);
        chk("blocks_drained", exp_q.size(), 0);

        // Five-cycle downstream stall in the middle of a stream.
        sent   = 0;
        base_c = n_consumed;
        for (int r = 0; r < 8; r++) x_arr[r] = rand_x();
        cur_tsel = 1'($urandom);
        cur_rnd  = 1'($urandom);
        for (int c = 0; c < 40; c++) begin
            out_ready = (c < 4 || c >= 9);
            if (sent < 12) set_beat(sent == 0, cur_tsel, cur_rnd);
            else begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
            end
            step();
            if (acc_flag) begin
                sent++;
                for (int r = 0; r < 8; r++) x_arr[r] = rand_x();
                cur_tsel = 1'($urandom);
                cur_rnd  = 1'($urandom);
            end
        end
        chk("stall_sent", sent, 12);
        chk("stall_consumed", n_consumed - base_c, 12);
        chk("stall_drained", exp_q.size(), 0);

        // Reset in the middle of a block, while column 4 is the next position.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 8; r++) x_arr[r] = rand_x();
            set_beat(i == 0, 0, 0);
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chkv("midrst_out_data", out_data, '0);
        exp_q.delete();
        m_cnt    = 0;
        m_tbl    = 1'b0;
        hold_chk = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        one_beat(0, 1, 0, 1000, 1000, l0, l7, col);
        chk("post_rst_col", col, 0);
        chk("post_rst_chroma_l0", l0, 62);
        chk("post_rst_chroma_l7", l7, 7);
        one_beat(0, 0, 0, 1000, 1000, l0, l7, col);
        chk("post_rst_col1", col, 1);
        chk("post_rst_latched_tbl", l0, 54);

        // Random traffic with random backpressure and occasional resyncs.
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            for (int r = 0; r < 8; r++) x_arr[r] = rand_x();
            set_beat($urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom));
            in_valid = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("random_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
